// File: rtl/falco_ifetch_responder.sv
// Falco instruction-fetch responder: looks fetch PCs up in a fuzzer-loaded buffer and
// returns them in order after a fixed latency through a credit-limited response FIFO.
module falco_ifetch_responder #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned INSN_W  = 32,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned QDEPTH  = 4,
    parameter int unsigned ID_W    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [XLEN-1:0]          base_pc,
    input  logic                     load_we,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [INSN_W-1:0]        load_data,
    input  logic                     flush,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [XLEN-1:0]          req_pc,
    input  logic [ID_W-1:0]          req_id,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [INSN_W-1:0]        resp_insn,
    output logic [XLEN-1:0]          resp_pc,
    output logic [ID_W-1:0]          resp_id,
    output logic                     resp_fault,
    output logic [15:0]              fault_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = $clog2(QDEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [ID_W-1:0]   id;
        logic [INSN_W-1:0] insn;
        logic              fault;
    } entry_t;

    logic [INSN_W-1:0] insn_mem [DEPTH];
    logic [CW-1:0]     outstanding_q;
    logic              accept;
    logic              handshake;

    // Credits: every accepted request owns a slot until its response handshakes.
    assign req_ready = !flush && (outstanding_q < CW'(QDEPTH));
    assign accept    = req_valid && req_ready;
    assign handshake = resp_valid && resp_ready;

    always_ff @(posedge clk) begin
        if (load_we) begin
            insn_mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding_q <= '0;
        end else if (flush) begin
            outstanding_q <= '0;
        end else if (accept && !handshake) begin
            outstanding_q <= outstanding_q + CW'(1);
        end else if (!accept && handshake) begin
            outstanding_q <= outstanding_q - CW'(1);
        end
    end

    // Lookup happens in the accept cycle, so a same-cycle load still sees the old word.
    logic [XLEN-1:0] off;
    logic [AW-1:0]   lk_idx;
    logic            lk_fault;
    logic            unused_off;
    entry_t          lkp;

    assign off        = req_pc - base_pc;
    assign lk_idx     = off[AW+1:2];
    assign lk_fault   = (req_pc[1:0] != 2'b00) || (req_pc < base_pc) || (off[XLEN-1:AW+2] != '0);
    assign unused_off = ^off[1:0];

    always_comb begin
        lkp       = '0;
        lkp.pc    = req_pc;
        lkp.id    = req_id;
        lkp.fault = lk_fault;
        lkp.insn  = lk_fault ? '0 : insn_mem[lk_idx];
    end

    logic   push_vld;
    entry_t push_data;

    generate
        if (LATENCY == 1) begin : g_nopipe
            assign push_vld  = accept;
            assign push_data = lkp;
        end else begin : g_pipe
            logic   vld_q [LATENCY-1];
            entry_t dat_q [LATENCY-1];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < int'(LATENCY) - 1; i++) begin
                        vld_q[i] <= 1'b0;
                        dat_q[i] <= '0;
                    end
                end else begin
                    vld_q[0] <= accept;
                    dat_q[0] <= lkp;
                    for (int i = 1; i < int'(LATENCY) - 1; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        dat_q[i] <= dat_q[i-1];
                    end
                    if (flush) begin
                        for (int i = 0; i < int'(LATENCY) - 1; i++) begin
                            vld_q[i] <= 1'b0;
                        end
                    end
                end
            end

            assign push_vld  = vld_q[LATENCY-2];
            assign push_data = dat_q[LATENCY-2];
        end
    endgenerate

    entry_t        fifo_q [QDEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_nxt;
    logic [CW-1:0] fcnt_q;
    logic [CW-1:0] fcnt_nxt;
    logic          valid_q;
    logic          valid_nxt;
    entry_t        head_q;
    entry_t        head_nxt;
    logic          push;
    logic          pop;

    assign push = push_vld && !flush;
    assign pop  = handshake;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_data;
        end
    end

    // Head register mirrors the FIFO's next oldest entry so the response port is registered.
    always_comb begin
        rd_ptr_nxt = rd_ptr_q;
        fcnt_nxt   = fcnt_q;
        valid_nxt  = valid_q;
        head_nxt   = head_q;
        if (flush) begin
            rd_ptr_nxt = wr_ptr_q;
            fcnt_nxt   = '0;
            valid_nxt  = 1'b0;
        end else begin
            rd_ptr_nxt = rd_ptr_q + PW'(pop);
            fcnt_nxt   = fcnt_q + CW'(push) - CW'(pop);
            valid_nxt  = (fcnt_nxt != '0);
            if (fcnt_q == CW'(pop)) begin
                if (push) begin
                    head_nxt = push_data;
                end
            end else begin
                head_nxt = fifo_q[rd_ptr_nxt];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PW'(push);
            rd_ptr_q <= rd_ptr_nxt;
            fcnt_q   <= fcnt_nxt;
            valid_q  <= valid_nxt;
            head_q   <= head_nxt;
        end
    end

    assign resp_valid = valid_q;
    assign resp_insn  = head_q.insn;
    assign resp_pc    = head_q.pc;
    assign resp_id    = head_q.id;
    assign resp_fault = head_q.fault;

    // Counts delivered faults, including a handshake that coincides with a flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_count <= '0;
        end else if (handshake && resp_fault && (fault_count != 16'hFFFF)) begin
            fault_count <= fault_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_falco_ifetch_responder.sv
// Bench for falco_ifetch_responder: directed scenarios plus randomized traffic checked
// against a transaction-level queue model of the responder.
module tb_falco_ifetch_responder;

    localparam int unsigned DEPTH = 256;
    localparam int LAT = 2;
    localparam int QD  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] base_pc;
    logic        load_we;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_pc;
    logic [3:0]  req_id;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_insn;
    logic [63:0] resp_pc;
    logic [3:0]  resp_id;
    logic        resp_fault;
    logic [15:0] fault_count;

    falco_ifetch_responder #(
        .XLEN(64), .INSN_W(32), .DEPTH(DEPTH), .LATENCY(LAT), .QDEPTH(QD), .ID_W(4)
    ) dut (
        .clk(clk), .rst(rst), .base_pc(base_pc),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
        .req_pc(req_pc), .req_id(req_id),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_insn(resp_insn),
        .resp_pc(resp_pc), .resp_id(resp_id), .resp_fault(resp_fault),
        .fault_count(fault_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [3:0]  id;
        logic [31:0] insn;
        logic        fault;
        int          rdy;
    } exp_t;

    // Model: outstanding requests in order, each with the earliest cycle it may be presented.
    exp_t        q[$];
    logic [31:0] mmem [DEPTH];
    logic [15:0] m_fc = 16'd0;
    int          cyc  = 0;
    int          vecs = 0;
    int          errs = 0;

    logic        s_rv, s_rdy, s_fault;
    logic [31:0] s_insn;
    logic [63:0] s_pc;
    logic [3:0]  s_id;
    logic [15:0] s_fc;
    logic        e_rv, e_rdy;
    logic [15:0] e_fc;
    exp_t        e_head;

    function automatic exp_t lookup(input logic [63:0] pc, input logic [3:0] id, input int now);
        exp_t        e;
        logic [63:0] off;
        off     = pc - base_pc;
        e.pc    = pc;
        e.id    = id;
        e.rdy   = now + LAT;
        e.fault = (pc % 64'd4 != 64'd0) || (pc < base_pc) || (off >= 64'(DEPTH * 4));
        e.insn  = e.fault ? 32'h0 : mmem[int'(off / 64'd4)];
        return e;
    endfunction

    // One clock: sample DUT and model at the falling edge, then advance the model.
    task automatic tick();
        @(negedge clk);
        s_rv = resp_valid; s_rdy = req_ready; s_insn = resp_insn; s_pc = resp_pc;
        s_id = resp_id; s_fault = resp_fault; s_fc = fault_count;
        e_rv  = (q.size() > 0) && (q[0].rdy <= cyc);
        e_rdy = !flush && (q.size() < QD);
        e_fc  = m_fc;
        if (q.size() > 0) e_head = q[0];
        else e_head = '{pc: 64'h0, id: 4'h0, insn: 32'h0, fault: 1'b0, rdy: 0};
        if (e_rv && resp_ready) begin
            if (q[0].fault && m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
            void'(q.pop_front());
        end
        if (flush) q.delete();
        if (req_valid && e_rdy) q.push_back(lookup(req_pc, req_id, cyc));
        if (load_we) mmem[load_addr] = load_data;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        req_valid = 1'b0; resp_ready = 1'b1; flush = 1'b0; load_we = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #2;
        vecs++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", resp_valid); end
        vecs++; if (resp_insn !== 32'h0) begin errs++; $display("FAIL reset_insn: got %h want 0", resp_insn); end
        vecs++; if (resp_pc !== 64'h0) begin errs++; $display("FAIL reset_pc: got %h want 0", resp_pc); end
        vecs++; if (resp_id !== 4'h0 || resp_fault !== 1'b0) begin errs++; $display("FAIL reset_id_fault: got %h/%b want 0/0", resp_id, resp_fault); end
        vecs++; if (fault_count !== 16'h0) begin errs++; $display("FAIL reset_fault_count: got %h want 0", fault_count); end
        #9 rst = 1'b1;
        @(posedge clk);
        #1;
        tick();
        vecs++; if (s_rdy !== 1'b1 || s_rv !== 1'b0) begin errs++; $display("FAIL reset_idle: got rdy=%b rv=%b want 1/0", s_rdy, s_rv); end
    endtask

    task automatic test_load();
        load_we = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            load_addr = 8'(i);
            case (i)
                0: load_data = 32'h00000013;
                1: load_data = 32'h00100093;
                2: load_data = 32'h00200113;
                3: load_data = 32'h00300193;
                5: load_data = 32'h00500293;
                default: load_data = $urandom;
            endcase
            tick();
        end
        load_we = 1'b0;
        vecs++; if (s_rdy !== 1'b1) begin errs++; $display("FAIL load_ready: got %b want 1", s_rdy); end
    endtask

    task automatic test_latency();
        int          seen;
        logic [31:0] words [4];
        words = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193};
        seen = 0;
        resp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req_valid = (k < 4); req_pc = 64'h8000_0000 + 64'(4 * k); req_id = 4'(k);
            tick();
            vecs++; if (s_rv !== ((k >= 2) && (k < 6))) begin errs++; $display("FAIL lat_valid k=%0d: got %b want %b", k, s_rv, (k >= 2) && (k < 6)); end
            if (s_rv === 1'b1 && seen < 4) begin
                vecs++;
                if (s_insn !== words[seen] || s_id !== 4'(seen) || s_fault !== 1'b0 || s_pc !== 64'h8000_0000 + 64'(4 * seen)) begin
                    errs++; $display("FAIL lat_resp %0d: got insn=%h id=%h pc=%h f=%b want insn=%h id=%h", seen, s_insn, s_id, s_pc, s_fault, words[seen], 4'(seen));
                end
                seen++;
            end
        end
        req_valid = 1'b0;
        vecs++; if (seen !== 4) begin errs++; $display("FAIL lat_count: got %0d want 4", seen); end
    endtask

    task automatic test_faults();
        logic [63:0] pcs [3];
        int          nf;
        pcs = '{64'h8000_0002, 64'h7FFF_FFFC, 64'h8000_0400};
        nf = 0;
        resp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req_valid = (k < 3); req_pc = pcs[(k < 3) ? k : 0]; req_id = 4'(k + 4);
            tick();
            if (s_rv === 1'b1) begin
                vecs++; if (s_fault !== 1'b1 || s_insn !== 32'h0) begin errs++; $display("FAIL fault_resp %0d: got f=%b insn=%h want 1/0", nf, s_fault, s_insn); end
                nf++;
            end
        end
        req_valid = 1'b0;
        vecs++; if (nf !== 3) begin errs++; $display("FAIL fault_resp_count: got %0d want 3", nf); end
        vecs++; if (fault_count !== 16'd3) begin errs++; $display("FAIL fault_count: got %0d want 3", fault_count); end
    endtask

    task automatic test_backpressure();
        int         acc;
        int         got;
        logic [3:0] nid;
        acc = 0; got = 0; nid = 4'd8;
        resp_ready = 1'b0; req_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            req_pc = 64'h8000_0000 + 64'(4 * acc); req_id = nid;
            tick();
            if (s_rdy === 1'b1) begin acc++; nid++; end
        end
        vecs++; if (acc !== 4) begin errs++; $display("FAIL bp_accepts: got %0d want 4", acc); end
        vecs++; if (s_rdy !== 1'b0) begin errs++; $display("FAIL bp_ready_low: got %b want 0", s_rdy); end
        req_valid = 1'b0; resp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 0) begin
                vecs++; if (s_rdy !== 1'b0 || s_rv !== 1'b1) begin errs++; $display("FAIL bp_first_hs: got rdy=%b rv=%b want 0/1", s_rdy, s_rv); end
            end
            if (k == 1) begin
                vecs++; if (s_rdy !== 1'b1) begin errs++; $display("FAIL bp_ready_return: got %b want 1", s_rdy); end
            end
            if (s_rv === 1'b1) begin
                vecs++; if (s_id !== 4'(8 + got) || s_insn !== mmem[got]) begin errs++; $display("FAIL bp_order %0d: got id=%h insn=%h want id=%h insn=%h", got, s_id, s_insn, 4'(8 + got), mmem[got]); end
                got++;
            end
        end
        vecs++; if (got !== 4) begin errs++; $display("FAIL bp_resp_count: got %0d want 4", got); end
    endtask

    task automatic test_simultaneous();
        logic [3:0] nid;
        nid = 4'd0;
        resp_ready = 1'b0; req_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req_pc = 64'h8000_0000 + 64'(4 * $urandom_range(0, 255)); req_id = nid;
            tick();
            if (s_rdy === 1'b1) nid++;
        end
        resp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            req_pc = 64'h8000_0000 + 64'(4 * $urandom_range(0, 255)); req_id = nid;
            tick();
            if (s_rdy === 1'b1) nid++;
            if (k == 0) begin
                vecs++; if (s_rdy !== 1'b0 || s_rv !== 1'b1) begin errs++; $display("FAIL sim_full: got rdy=%b rv=%b want 0/1", s_rdy, s_rv); end
            end
            if (k == 1 || k == 2) begin
                vecs++; if (s_rdy !== 1'b1 || s_rv !== 1'b1) begin errs++; $display("FAIL sim_count3 k=%0d: got rdy=%b rv=%b want 1/1", k, s_rdy, s_rv); end
            end
            vecs++; if (s_rdy !== e_rdy || s_rv !== e_rv) begin errs++; $display("FAIL sim_model k=%0d: got rdy=%b rv=%b want %b/%b", k, s_rdy, s_rv, e_rdy, e_rv); end
            if (e_rv) begin
                vecs++; if (s_id !== e_head.id || s_insn !== e_head.insn) begin errs++; $display("FAIL sim_resp k=%0d: got id=%h insn=%h want id=%h insn=%h", k, s_id, s_insn, e_head.id, e_head.insn); end
            end
        end
        drain(8);
    endtask

    task automatic test_collision();
        int          got;
        logic [31:0] want;
        got = 0;
        resp_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            load_we = (k == 0); load_addr = 8'd5; load_data = 32'hDEADBEEF;
            req_valid = (k < 2); req_pc = 64'h8000_0014; req_id = 4'(k + 1);
            tick();
            if (s_rv === 1'b1) begin
                want = (got == 0) ? 32'h00500293 : 32'hDEADBEEF;
                vecs++; if (s_insn !== want || s_fault !== 1'b0) begin errs++; $display("FAIL collide %0d: got insn=%h f=%b want %h/0", got, s_insn, s_fault, want); end
                got++;
            end
        end
        load_we = 1'b0; req_valid = 1'b0;
        vecs++; if (got !== 2) begin errs++; $display("FAIL collide_count: got %0d want 2", got); end
    endtask

    task automatic test_flush();
        logic [63:0] pcs [3];
        logic [15:0] fc0;
        pcs = '{64'h8000_0001, 64'h8000_0004, 64'h8000_0008};
        fc0 = m_fc;
        resp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            req_valid = (k < 3); req_pc = pcs[(k < 3) ? k : 0]; req_id = 4'(k + 1);
            tick();
        end
        req_valid = 1'b0; flush = 1'b1; resp_ready = 1'b1;
        tick();
        vecs++; if (s_rv !== 1'b1 || s_fault !== 1'b1 || s_rdy !== 1'b0) begin errs++; $display("FAIL flush_cycle: got rv=%b f=%b rdy=%b want 1/1/0", s_rv, s_fault, s_rdy); end
        flush = 1'b0;
        tick();
        vecs++; if (s_rv !== 1'b0 || s_rdy !== 1'b1) begin errs++; $display("FAIL flush_next: got rv=%b rdy=%b want 0/1", s_rv, s_rdy); end
        vecs++; if (s_fc !== fc0 + 16'd1) begin errs++; $display("FAIL flush_fault_count: got %0d want %0d", s_fc, fc0 + 16'd1); end
        for (int k = 0; k < 5; k++) begin
            tick();
            vecs++; if (s_rv !== 1'b0) begin errs++; $display("FAIL flush_stale k=%0d: got rv=%b want 0", k, s_rv); end
        end
    endtask

    task automatic test_random();
        int r;
        for (int k = 0; k < 500; k++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       req_pc = 64'h8000_0000 + 64'(4 * $urandom_range(0, 255));
            else if (r == 7) req_pc = 64'h8000_0000 + 64'($urandom_range(0, 1023));
            else if (r == 8) req_pc = 64'h8000_0000 - 64'(4 * $urandom_range(1, 4));
            else             req_pc = 64'h8000_0400 + 64'(4 * $urandom_range(0, 100));
            req_id     = 4'($urandom);
            req_valid  = ($urandom_range(0, 2) != 0);
            resp_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 29) == 0);
            load_we    = ($urandom_range(0, 5) == 0);
            load_addr  = 8'($urandom);
            load_data  = $urandom;
            tick();
            vecs++; if (s_rv !== e_rv) begin errs++; $display("FAIL rand_valid cyc=%0d: got %b want %b", cyc, s_rv, e_rv); end
            vecs++; if (s_rdy !== e_rdy) begin errs++; $display("FAIL rand_ready cyc=%0d: got %b want %b", cyc, s_rdy, e_rdy); end
            vecs++; if (s_fc !== e_fc) begin errs++; $display("FAIL rand_fault_count cyc=%0d: got %0d want %0d", cyc, s_fc, e_fc); end
            if (e_rv) begin
                vecs++;
                if (s_insn !== e_head.insn || s_pc !== e_head.pc || s_id !== e_head.id || s_fault !== e_head.fault) begin
                    errs++; $display("FAIL rand_resp cyc=%0d: got insn=%h pc=%h id=%h f=%b want insn=%h pc=%h id=%h f=%b", cyc, s_insn, s_pc, s_id, s_fault, e_head.insn, e_head.pc, e_head.id, e_head.fault);
                end
            end
        end
        drain(8);
    endtask

    task automatic test_async_reset();
        resp_ready = 1'b0; req_valid = 1'b1; req_pc = 64'h8000_0000; req_id = 4'd3;
        repeat (4) tick();
        #2 rst = 1'b0;
        #1;
        vecs++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL arst_valid: got %b want 0", resp_valid); end
        vecs++; if (resp_insn !== 32'h0 || resp_pc !== 64'h0) begin errs++; $display("FAIL arst_data: got insn=%h pc=%h want 0/0", resp_insn, resp_pc); end
        vecs++; if (resp_id !== 4'h0 || resp_fault !== 1'b0) begin errs++; $display("FAIL arst_id_fault: got %h/%b want 0/0", resp_id, resp_fault); end
        vecs++; if (fault_count !== 16'h0) begin errs++; $display("FAIL arst_fault_count: got %0d want 0", fault_count); end
        vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL arst_ready: got %b want 1", req_ready); end
        req_valid = 1'b0;
        q.delete();
        m_fc = 16'd0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req_valid = (k == 0); req_pc = 64'h8000_0008; req_id = 4'd7;
            tick();
            vecs++; if (s_rv !== e_rv) begin errs++; $display("FAIL arst_after k=%0d: got rv=%b want %b", k, s_rv, e_rv); end
            if (e_rv) begin
                vecs++; if (s_insn !== e_head.insn || s_id !== 4'd7) begin errs++; $display("FAIL arst_resp: got insn=%h id=%h want insn=%h id=7", s_insn, s_id, e_head.insn); end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; base_pc = 64'h8000_0000;
        load_we = 1'b0; load_addr = 8'h0; load_data = 32'h0;
        flush = 1'b0; req_valid = 1'b0; req_pc = 64'h0; req_id = 4'h0; resp_ready = 1'b0;
        test_reset();
        test_load();
        test_latency();
        drain(4);
        test_faults();
        drain(4);
        test_backpressure();
        drain(4);
        test_simultaneous();
        test_collision();
        drain(4);
        test_flush();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
